// File: rtl/conv_encoder_punct_pkg.sv
// Shared constants for the K=3 rate-1/2 encoder and its Viterbi decoder.
// Holds the generator taps, the trellis state codes and the encoder FSM state type.
package viterbi_pkg;
  localparam int            K   = 3;
  localparam logic [K-1:0]  G1  = 3'b111;
  localparam logic [K-1:0]  G0  = 3'b101;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} enc_state_t;

  // Tap word is {u(n), u(n-1), u(n-2)}; sr holds {u(n-2), u(n-1)}.
  function automatic logic [1:0] conv_enc(input logic u, input logic [1:0] sr);
    logic [K-1:0] w;
    w = {u, sr[0], sr[1]};
    return {^(w & G1), ^(w & G0)};
  endfunction
endpackage

// File: rtl/conv_encoder_punct_if.sv
// Source-side handshake and parity-enable bus of the puncturing encoder.
// The tri-stated parity pair itself is a plain wire port on the encoder.
interface conv_encoder_punct_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] parity_en;
  logic       out_valid;

  modport master (output in_bit, in_valid, in_last,
                  input  in_ready, parity_en, out_valid);
  modport slave  (input  in_bit, in_valid, in_last,
                  output in_ready, parity_en, out_valid);
endinterface

// File: rtl/conv_encoder_punct_sel.sv
// Puncture step counter and keep-mask lookup.
// Steps advance per accepted data bit and restart at step 0 for each frame.
module punct_sel #(
  parameter int         PUNCT_LEN  = 2,
  parameter logic [7:0] PUNCT_MASK = 8'b0000_1011
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_adv,
  input  logic       i_clr,
  output logic [1:0] o_keep
);
  logic [1:0] r_idx;
  logic [1:0] w_raw;
  logic [1:0] w_last_idx;

  assign w_last_idx = 2'(PUNCT_LEN - 1);
  assign w_raw      = PUNCT_MASK[{r_idx, 1'b0} +: 2];
  // An all-punctured step would starve the decoder, so it degrades to keep-both.
  assign o_keep     = (w_raw == 2'b00) ? 2'b11 : w_raw;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx <= 2'd0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
    end else if (i_adv) begin
      r_idx <= (r_idx == w_last_idx) ? 2'd0 : r_idx + 2'd1;
    end
  end

  a_mask_step_legal: assert property (@(posedge CLK) disable iff (!RST_N)
    i_adv |-> (w_raw != 2'b00));
endmodule

// File: rtl/conv_encoder_punct.sv
// Rate-1/2 K=3 convolutional encoder with programmable puncturing and 2-bit zero tail.
// state | meaning
// IDLE  | waiting for the first bit of a frame
// DATA  | mid-frame, encoding source bits (bubble when none offered)
// TAIL1 | flushing first zero tail bit, source stalled
// TAIL2 | flushing second zero tail bit, trellis returns to 00
module conv_encoder_punct
  import viterbi_pkg::*;
#(
  parameter int         PUNCT_LEN  = 2,
  parameter logic [7:0] PUNCT_MASK = 8'b0000_1011
) (
  input  logic               CLK,
  input  logic               RST_N,
  conv_encoder_punct_if.slave bus,
  output wire  [1:0]         parities
);
  enc_state_t r_state;
  logic [1:0] r_sr;
  logic [1:0] r_par;
  logic [1:0] r_en;

  logic       w_rdy;
  logic       w_acc;
  logic       w_u;
  logic [1:0] w_par;
  logic [1:0] w_keep;

  assign w_rdy = (r_state == IDLE) || (r_state == DATA);
  assign w_acc = bus.in_valid & w_rdy;
  assign w_u   = w_rdy ? bus.in_bit : 1'b0;
  assign w_par = conv_enc(w_u, r_sr);

  punct_sel #(.PUNCT_LEN(PUNCT_LEN), .PUNCT_MASK(PUNCT_MASK)) u_punct_sel (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_adv  (w_acc),
    .i_clr  (w_acc & bus.in_last),
    .o_keep (w_keep)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_sr    <= S00;
      r_par   <= 2'b00;
      r_en    <= 2'b00;
    end else begin
      case (r_state)
        IDLE, DATA: begin
          if (w_acc) begin
            r_sr    <= {r_sr[0], w_u};
            r_par   <= w_par;
            r_en    <= w_keep;
            r_state <= bus.in_last ? TAIL1 : DATA;
          end else begin
            r_en    <= 2'b00;
          end
        end
        TAIL1: begin
          r_sr    <= {r_sr[0], 1'b0};
          r_par   <= w_par;
          r_en    <= 2'b11;
          r_state <= TAIL2;
        end
        TAIL2: begin
          r_sr    <= {r_sr[0], 1'b0};
          r_par   <= w_par;
          r_en    <= 2'b11;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 2'b00;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_rdy;
  assign bus.parity_en = r_en;
  assign bus.out_valid = |r_en;

  assign parities[1] = r_en[1] ? r_par[1] : 1'bz;
  assign parities[0] = r_en[0] ? r_par[0] : 1'bz;
endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed and model-checked bench for conv_encoder_punct.
// Instance A: PUNCT_LEN=1 keep-all; instance B: default rate-2/3 pattern.
module tb_conv_encoder_punct;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  conv_encoder_punct_if ifa ();
  conv_encoder_punct_if ifb ();
  wire [1:0] par_a;
  wire [1:0] par_b;

  conv_encoder_punct #(.PUNCT_LEN(1), .PUNCT_MASK(8'h03)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(ifa.slave), .parities(par_a));
  conv_encoder_punct dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(ifb.slave), .parities(par_b));

  typedef struct packed {
    bit       sel;
    bit       v, b, l;
    bit       rdy;
    bit [1:0] en, par, sr;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(bit sel, bit v, bit b, bit l, bit rdy,
                              bit [1:0] en, bit [1:0] par, bit [1:0] sr);
    vec_t r;
    r.sel = sel; r.v = v; r.b = b; r.l = l; r.rdy = rdy;
    r.en = en; r.par = par; r.sr = sr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit sel, input bit v, input bit b, input bit l);
    ifa.in_valid = sel ? 1'b0 : v;
    ifa.in_bit   = b;
    ifa.in_last  = l;
    ifb.in_valid = sel ? v : 1'b0;
    ifb.in_bit   = b;
    ifb.in_last  = l;
  endtask

  function automatic bit [1:0] model_enc(bit u, bit [1:0] s);
    return {u ^ s[0] ^ s[1], u ^ s[1]};
  endfunction

  task automatic run_row(input vec_t r, input int n);
    logic [1:0] en, par, sr;
    logic rdy, ov;
    string tag;
    drive(r.sel, r.v, r.b, r.l);
    #1;
    rdy = r.sel ? ifb.in_ready : ifa.in_ready;
    tag = $sformatf("row%0d", n);
    chk({tag, "_ready"}, {7'd0, rdy}, {7'd0, r.rdy});
    tick();
    en  = r.sel ? ifb.parity_en : ifa.parity_en;
    par = r.sel ? par_b : par_a;
    ov  = r.sel ? ifb.out_valid : ifa.out_valid;
    sr  = r.sel ? dut_b.r_sr : dut_a.r_sr;
    chk({tag, "_en"},  {6'd0, en}, {6'd0, r.en});
    chk({tag, "_par"}, {6'd0, par & r.en}, {6'd0, r.par & r.en});
    chk({tag, "_ov"},  {7'd0, ov}, {7'd0, |r.en});
    chk({tag, "_sr"},  {6'd0, sr}, {6'd0, r.sr});
  endtask

  initial begin
    int low_cnt;
    bit [1:0] m_sr, e_en, e_par;
    bit m_idx;
    int m_tail, sent, cyc;
    bit v, b, l;

    drive(0, 0, 0, 0);
    // Scenario 1: keep-all
    tbl.push_back(mk(0,1,1,0,1,2'b11,2'b11,2'b01));
    tbl.push_back(mk(0,1,0,0,1,2'b11,2'b10,2'b10));
    tbl.push_back(mk(0,1,1,0,1,2'b11,2'b00,2'b01));
    tbl.push_back(mk(0,1,1,1,1,2'b11,2'b01,2'b11));
    tbl.push_back(mk(0,0,0,0,0,2'b11,2'b01,2'b10));
    tbl.push_back(mk(0,0,0,0,0,2'b11,2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00));
    // Scenario 2: rate 2/3
    tbl.push_back(mk(1,1,1,0,1,2'b11,2'b11,2'b01));
    tbl.push_back(mk(1,1,0,0,1,2'b10,2'b10,2'b10));
    tbl.push_back(mk(1,1,1,0,1,2'b11,2'b00,2'b01));
    tbl.push_back(mk(1,1,1,1,1,2'b10,2'b00,2'b11));
    tbl.push_back(mk(1,0,0,0,0,2'b11,2'b01,2'b10));
    tbl.push_back(mk(1,0,0,0,0,2'b11,2'b11,2'b00));
    tbl.push_back(mk(1,0,0,0,1,2'b00,2'b00,2'b00));
    // Scenario 3: bubbles mid-frame
    tbl.push_back(mk(1,1,1,0,1,2'b11,2'b11,2'b01));
    tbl.push_back(mk(1,1,0,0,1,2'b10,2'b10,2'b10));
    tbl.push_back(mk(1,0,0,0,1,2'b00,2'b00,2'b10));
    tbl.push_back(mk(1,0,0,0,1,2'b00,2'b00,2'b10));
    tbl.push_back(mk(1,0,0,0,1,2'b00,2'b00,2'b10));
    tbl.push_back(mk(1,1,1,0,1,2'b11,2'b00,2'b01));
    tbl.push_back(mk(1,1,1,1,1,2'b10,2'b00,2'b11));
    tbl.push_back(mk(1,0,0,0,0,2'b11,2'b01,2'b10));
    tbl.push_back(mk(1,0,0,0,0,2'b11,2'b11,2'b00));
    tbl.push_back(mk(1,0,0,0,1,2'b00,2'b00,2'b00));

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_en_a", {6'd0, ifa.parity_en}, 8'd0);
    chk("rst_en_b", {6'd0, ifb.parity_en}, 8'd0);
    chk("rst_ov_b", {7'd0, ifb.out_valid}, 8'd0);
    chk("rst_rdy_b", {7'd0, ifb.in_ready}, 8'd1);
    chk("rst_sr_b", {6'd0, dut_b.r_sr}, 8'd0);
    @(posedge CLK);
    #1;

    foreach (tbl[i]) run_row(tbl[i], i);

    // Reset during the third data bit
    drive(1, 1, 1, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 1, 0);
    #2 RST_N = 1'b0;
    tick();
    chk("midrst_en", {6'd0, ifb.parity_en}, 8'd0);
    chk("midrst_ov", {7'd0, ifb.out_valid}, 8'd0);
    chk("midrst_rdy", {7'd0, ifb.in_ready}, 8'd1);
    chk("midrst_sr", {6'd0, dut_b.r_sr}, 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1, 1, 1, 1);
    tick();
    chk("midrst_new_en", {6'd0, ifb.parity_en}, 8'h03);
    chk("midrst_new_par", {6'd0, par_b}, 8'h03);
    drive(1, 0, 0, 0);
    repeat (3) tick();
    chk("midrst_end_sr", {6'd0, dut_b.r_sr}, 8'd0);

    // Back-to-back frames with in_valid held through the tail
    low_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, (c < 2) ? 1'b1 : 1'b0, (c >= 1) ? 1'b1 : 1'b0);
      #1;
      if (!ifb.in_ready) low_cnt++;
      tick();
    end
    chk("b2b_rdy_low", low_cnt[7:0], 8'd2);
    chk("b2b_first_en", {6'd0, ifb.parity_en}, 8'h03);
    chk("b2b_first_par", {6'd0, par_b}, 8'h00);
    drive(1, 0, 0, 0);
    repeat (3) tick();

    // Random 32-bit frame with random gaps against a reference model
    m_sr = 2'b00; m_idx = 1'b0; m_tail = 0; sent = 0; cyc = 0;
    while (!(sent == 32 && m_tail == 0) && cyc < 400) begin
      v = ($urandom_range(0, 3) != 0) && (sent < 32);
      b = 1'($urandom_range(0, 1));
      l = v && (sent == 31);
      drive(1, v, b, l);
      #1;
      chk("rnd_rdy", {7'd0, ifb.in_ready}, {7'd0, (m_tail == 0)});
      if (m_tail != 0) begin
        e_par = model_enc(1'b0, m_sr); e_en = 2'b11;
        m_sr = {m_sr[0], 1'b0};
        m_tail = (m_tail == 1) ? 2 : 0;
      end else if (v) begin
        e_par = model_enc(b, m_sr); e_en = m_idx ? 2'b10 : 2'b11;
        m_sr = {m_sr[0], b};
        m_idx = l ? 1'b0 : ~m_idx;
        if (l) m_tail = 1;
        sent++;
      end else begin
        e_par = 2'b00; e_en = 2'b00;
      end
      tick();
      chk("rnd_en", {6'd0, ifb.parity_en}, {6'd0, e_en});
      chk("rnd_par", {6'd0, par_b & e_en}, {6'd0, e_par & e_en});
      chk("rnd_ov", {7'd0, ifb.out_valid}, {7'd0, |e_en});
      cyc++;
    end
    chk("rnd_done", {7'd0, (cyc < 400)}, 8'd1);
    chk("rnd_end_sr", {6'd0, dut_b.r_sr}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
